// File: rtl/id_stage_if.sv
// id_stage_if: fetch, writeback and ID/EX signal bundle around the RV32I decode stage
interface id_stage_if #(
  parameter int XLEN = 32
);
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc, if_pc4;
  logic            ex_redirect;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall_pc;
  logic [XLEN-1:0] pc_update;
  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_pc, id_ex_pc4, id_ex_rs1d, id_ex_rs2d, id_ex_imm;
  logic [4:0]      id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [3:0]      id_ex_alu_op;
  logic            id_ex_asel, id_ex_bsel, id_ex_branch, id_ex_jump;
  logic            id_ex_mem_re, id_ex_mem_we, id_ex_reg_we;
  logic [2:0]      id_ex_funct3;
  logic [1:0]      id_ex_wb_sel;
  modport master (
    output if_instr, if_pc, if_pc4, ex_redirect, wb_we, wb_rd, wb_data,
    input  stall_pc, pc_update, id_ex_valid, id_ex_pc, id_ex_pc4, id_ex_rs1d, id_ex_rs2d,
           id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_alu_op, id_ex_asel, id_ex_bsel,
           id_ex_branch, id_ex_jump, id_ex_mem_re, id_ex_mem_we, id_ex_reg_we, id_ex_funct3,
           id_ex_wb_sel
  );
  modport slave (
    input  if_instr, if_pc, if_pc4, ex_redirect, wb_we, wb_rd, wb_data,
    output stall_pc, pc_update, id_ex_valid, id_ex_pc, id_ex_pc4, id_ex_rs1d, id_ex_rs2d,
           id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_alu_op, id_ex_asel, id_ex_bsel,
           id_ex_branch, id_ex_jump, id_ex_mem_re, id_ex_mem_we, id_ex_reg_we, id_ex_funct3,
           id_ex_wb_sel
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: RV32I decode with regfile, immediate/control decode, load-use stall and wrong-path squash
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);
  typedef enum logic {RUN, SQUASH} state_t;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, pc4, rs1d, rs2d, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [3:0]      alu_op;
    logic            asel, bsel, branch, jump, mem_re, mem_we;
    logic [2:0]      funct3;
    logic            reg_we;
    logic [1:0]      wb_sel;
  } idex_t;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_OP = 7'h33;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4;
  localparam logic [3:0] A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8, A_AND = 4'd9;
  localparam logic [3:0] A_PASSB = 4'd10;
  state_t          r_state, w_next;
  idex_t           r_ex, w_dec;
  logic [XLEN-1:0] r_rf [NREGS];
  logic [31:0]     w_in, w_imm;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [3:0]      w_alu;
  logic [XLEN-1:0] w_rs1d, w_rs2d;
  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_opi, w_op, w_legal;
  logic w_hz, w_stall, w_load;
  assign w_in    = bus.if_instr;
  assign w_f3    = w_in[14:12];
  assign w_lui   = w_in[6:0] == OP_LUI;
  assign w_auipc = w_in[6:0] == OP_AUIPC;
  assign w_jal   = w_in[6:0] == OP_JAL;
  assign w_jalr  = w_in[6:0] == OP_JALR;
  assign w_br    = w_in[6:0] == OP_BR;
  assign w_ld    = w_in[6:0] == OP_LD;
  assign w_st    = w_in[6:0] == OP_ST;
  assign w_opi   = w_in[6:0] == OP_IMM;
  assign w_op    = w_in[6:0] == OP_OP;
  assign w_legal = w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st | w_opi | w_op;
  // Unused source/dest fields are zeroed so forwarding and hazard compares never see phantom registers
  assign w_rs1 = (w_jalr | w_br | w_ld | w_st | w_opi | w_op) ? w_in[19:15] : '0;
  assign w_rs2 = (w_br | w_st | w_op) ? w_in[24:20] : '0;
  assign w_rd  = (w_legal & ~w_br & ~w_st) ? w_in[11:7] : '0;
  assign w_rs1d = (w_rs1 == '0) ? '0 : (bus.wb_we && bus.wb_rd == w_rs1) ? bus.wb_data : r_rf[w_rs1];
  assign w_rs2d = (w_rs2 == '0) ? '0 : (bus.wb_we && bus.wb_rd == w_rs2) ? bus.wb_data : r_rf[w_rs2];
  assign w_imm = (w_lui | w_auipc) ? {w_in[31:12], 12'h000} :
                 w_jal ? {{11{w_in[31]}}, w_in[31], w_in[19:12], w_in[20], w_in[30:21], 1'b0} :
                 w_st  ? {{20{w_in[31]}}, w_in[31:25], w_in[11:7]} :
                 w_br  ? {{19{w_in[31]}}, w_in[31], w_in[7], w_in[30:25], w_in[11:8], 1'b0} :
                 w_op  ? 32'h0 : {{20{w_in[31]}}, w_in[31:20]};
  assign w_alu = w_lui ? A_PASSB : ~(w_op | w_opi) ? A_ADD :
                 (w_f3 == 3'd0) ? ((w_op & w_in[30]) ? A_SUB : A_ADD) :
                 (w_f3 == 3'd5) ? (w_in[30] ? A_SRA : A_SRL) :
                 (w_f3 == 3'd1) ? A_SLL : (w_f3 == 3'd2) ? A_SLT : (w_f3 == 3'd3) ? A_SLTU :
                 (w_f3 == 3'd4) ? A_XOR : (w_f3 == 3'd6) ? A_OR : A_AND;
  assign w_hz = (r_state == RUN) & r_ex.valid & r_ex.mem_re & (r_ex.rd != '0) &
                ((w_rs1 == r_ex.rd) | (w_rs2 == r_ex.rd));
  assign w_stall = ~rst & w_hz & ~bus.ex_redirect;
  // ID/EX payload for the instruction in ID; all-zero bubble for unsupported opcodes
  always_comb begin
    w_dec = '0;
    if (w_legal) begin
      w_dec.valid  = 1'b1;
      w_dec.pc     = bus.if_pc;
      w_dec.pc4    = bus.if_pc4;
      w_dec.rs1d   = w_rs1d;
      w_dec.rs2d   = w_rs2d;
      w_dec.imm    = w_imm;
      w_dec.rs1    = w_rs1;
      w_dec.rs2    = w_rs2;
      w_dec.rd     = w_rd;
      w_dec.alu_op = w_alu;
      w_dec.asel   = w_auipc | w_jal | w_br;
      w_dec.bsel   = ~w_op;
      w_dec.branch = w_br;
      w_dec.jump   = w_jal | w_jalr;
      w_dec.mem_re = w_ld;
      w_dec.mem_we = w_st;
      w_dec.funct3 = (w_lui | w_auipc | w_jal) ? 3'd0 : w_f3;
      w_dec.reg_we = w_rd != '0;
      w_dec.wb_sel = (w_jal | w_jalr) ? 2'd2 : w_ld ? 2'd1 : 2'd0;
    end
  end
  // A redirect or a load-use stall makes the next ID slot stale; only RUN with neither loads decode
  always_comb begin
    w_next = (bus.ex_redirect | w_hz) ? SQUASH : RUN;
    w_load = (r_state == RUN) & ~bus.ex_redirect & ~w_hz;
  end
  // State register and ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_ex    <= '0;
    end else begin
      r_state <= w_next;
      r_ex    <= w_load ? w_dec : '0;
    end
  end
  // Architectural register file; x0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    else if (bus.wb_we && bus.wb_rd != '0) r_rf[bus.wb_rd] <= bus.wb_data;
  end
  assign bus.stall_pc     = w_stall;
  assign bus.pc_update    = bus.if_pc;
  assign bus.id_ex_valid  = r_ex.valid;
  assign bus.id_ex_pc     = r_ex.pc;
  assign bus.id_ex_pc4    = r_ex.pc4;
  assign bus.id_ex_rs1d   = r_ex.rs1d;
  assign bus.id_ex_rs2d   = r_ex.rs2d;
  assign bus.id_ex_imm    = r_ex.imm;
  assign bus.id_ex_rs1    = r_ex.rs1;
  assign bus.id_ex_rs2    = r_ex.rs2;
  assign bus.id_ex_rd     = r_ex.rd;
  assign bus.id_ex_alu_op = r_ex.alu_op;
  assign bus.id_ex_asel   = r_ex.asel;
  assign bus.id_ex_bsel   = r_ex.bsel;
  assign bus.id_ex_branch = r_ex.branch;
  assign bus.id_ex_jump   = r_ex.jump;
  assign bus.id_ex_mem_re = r_ex.mem_re;
  assign bus.id_ex_mem_we = r_ex.mem_we;
  assign bus.id_ex_funct3 = r_ex.funct3;
  assign bus.id_ex_reg_we = r_ex.reg_we;
  assign bus.id_ex_wb_sel = r_ex.wb_sel;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and random checks of id_stage against an instruction-level reference model
module tb_id_stage;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, pc4, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic        asel, bsel, branch, jump, mem_re, mem_we;
    logic [2:0]  funct3;
    logic        reg_we;
    logic [1:0]  wb_sel;
  } ex_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] m_rf [32];
  ex_t m_ex;
  bit m_stale;
  ex_t p_g;
  bit p_hz, p_redir, p_we;
  logic [4:0] p_wrd;
  logic [31:0] p_wd;
  id_stage_if b ();
  id_stage dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [191:0] a, input logic [191:0] e);
    checks++;
    assert (a === e) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, a, e);
    end
  endtask
  function automatic ex_t act();
    ex_t a;
    a.valid = b.id_ex_valid; a.pc = b.id_ex_pc; a.pc4 = b.id_ex_pc4;
    a.rs1d = b.id_ex_rs1d; a.rs2d = b.id_ex_rs2d; a.imm = b.id_ex_imm;
    a.rs1 = b.id_ex_rs1; a.rs2 = b.id_ex_rs2; a.rd = b.id_ex_rd; a.alu_op = b.id_ex_alu_op;
    a.asel = b.id_ex_asel; a.bsel = b.id_ex_bsel; a.branch = b.id_ex_branch; a.jump = b.id_ex_jump;
    a.mem_re = b.id_ex_mem_re; a.mem_we = b.id_ex_mem_we; a.funct3 = b.id_ex_funct3;
    a.reg_we = b.id_ex_reg_we; a.wb_sel = b.id_ex_wb_sel;
    return a;
  endfunction
  function automatic logic [31:0] rdv(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (b.wb_we && b.wb_rd == r) return b.wb_data;
    return m_rf[r];
  endfunction
  function automatic ex_t golden(input logic [31:0] in, input logic [31:0] pc);
    ex_t e;
    logic [3:0] tab [8];
    bit r1, r2, wr;
    int imm_i, imm_s, imm_b, imm_u, imm_j;
    tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    e = '0; r1 = 0; r2 = 0; wr = 0;
    imm_i = int'(in[31:20]) - (in[31] ? 4096 : 0);
    imm_s = int'({in[31:25], in[11:7]}) - (in[31] ? 4096 : 0);
    imm_b = int'({in[31], in[7], in[30:25], in[11:8], 1'b0}) - (in[31] ? 8192 : 0);
    imm_j = int'({in[31], in[19:12], in[20], in[30:21], 1'b0}) - (in[31] ? 2097152 : 0);
    imm_u = int'({in[31:12], 12'h000});
    case (in[6:0])
      7'h37: begin e.valid = 1; wr = 1; e.imm = imm_u; e.alu_op = 4'd10; e.bsel = 1; end
      7'h17: begin e.valid = 1; wr = 1; e.imm = imm_u; e.asel = 1; e.bsel = 1; end
      7'h6f: begin e.valid = 1; wr = 1; e.imm = imm_j; e.asel = 1; e.bsel = 1; e.jump = 1; e.wb_sel = 2; end
      7'h67: begin e.valid = 1; wr = 1; r1 = 1; e.imm = imm_i; e.bsel = 1; e.jump = 1; e.wb_sel = 2; e.funct3 = in[14:12]; end
      7'h63: begin e.valid = 1; r1 = 1; r2 = 1; e.imm = imm_b; e.asel = 1; e.bsel = 1; e.branch = 1; e.funct3 = in[14:12]; end
      7'h03: begin e.valid = 1; wr = 1; r1 = 1; e.imm = imm_i; e.bsel = 1; e.mem_re = 1; e.wb_sel = 1; e.funct3 = in[14:12]; end
      7'h23: begin e.valid = 1; r1 = 1; r2 = 1; e.imm = imm_s; e.bsel = 1; e.mem_we = 1; e.funct3 = in[14:12]; end
      7'h13: begin
        e.valid = 1; wr = 1; r1 = 1; e.imm = imm_i; e.bsel = 1; e.funct3 = in[14:12];
        e.alu_op = (in[14:12] == 3'd5 && in[30]) ? 4'd7 : tab[in[14:12]];
      end
      7'h33: begin
        e.valid = 1; wr = 1; r1 = 1; r2 = 1; e.funct3 = in[14:12];
        e.alu_op = (in[14:12] == 3'd5 && in[30]) ? 4'd7 : (in[14:12] == 3'd0 && in[30]) ? 4'd1 : tab[in[14:12]];
      end
      default: e = '0;
    endcase
    if (!e.valid) return '0;
    e.pc = pc;
    e.pc4 = pc + 32'd4;
    e.rs1 = r1 ? in[19:15] : 5'd0;
    e.rs2 = r2 ? in[24:20] : 5'd0;
    e.rd = wr ? in[11:7] : 5'd0;
    e.reg_we = e.rd != 5'd0;
    e.rs1d = rdv(e.rs1);
    e.rs2d = rdv(e.rs2);
    return e;
  endfunction
  function automatic logic [31:0] i_addi(input logic [4:0] rd, rs1, input logic [11:0] im);
    return {im, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] i_add(input logic [4:0] rd, rs1, rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] i_lw(input logic [4:0] rd, rs1, input logic [11:0] im);
    return {im, rs1, 3'b010, rd, 7'h03};
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] rs2, rs1, input logic [11:0] im);
    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] i_beq(input logic [4:0] rs1, rs2, input logic [12:0] im);
    return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] i_jal(input logic [4:0] rd, input logic [20:0] im);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
  endfunction
  task automatic drive(input logic [31:0] in, pc, input logic redir, we, input logic [4:0] wrd, input logic [31:0] wd);
    b.if_instr = in; b.if_pc = pc; b.if_pc4 = pc + 32'd4; b.ex_redirect = redir;
    b.wb_we = we; b.wb_rd = wrd; b.wb_data = wd;
    #1;
    p_g = golden(in, pc);
    p_hz = !m_stale && m_ex.valid && m_ex.mem_re && m_ex.rd != 5'd0 &&
           ((p_g.rs1 == m_ex.rd) || (p_g.rs2 == m_ex.rd));
    p_redir = redir; p_we = we; p_wrd = wrd; p_wd = wd;
    chk("stall_pc", b.stall_pc, p_hz && !redir);
    chk("pc_update", b.pc_update, pc);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    m_ex = (!m_stale && !p_redir && !p_hz) ? p_g : '0;
    m_stale = p_redir || p_hz;
    if (p_we && p_wrd != 5'd0) m_rf[p_wrd] = p_wd;
    chk("id_ex", act(), m_ex);
  endtask
  task automatic cyc(input logic [31:0] in, pc, input logic redir, we, input logic [4:0] wrd, input logic [31:0] wd);
    drive(in, pc, redir, we, wrd, wd);
    tick();
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_ex = '0;
    m_stale = 0;
  endtask
  initial begin
    logic [6:0] ops [9];
    logic [31:0] in;
    ex_t z;
    int k;
    z = '0;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    b.if_instr = 32'h0; b.if_pc = 32'h0; b.if_pc4 = 32'h4; b.ex_redirect = 1'b0;
    b.wb_we = 1'b0; b.wb_rd = 5'd0; b.wb_data = 32'h0;
    model_reset();
    #2;
    chk("rst_idex", act(), z);
    chk("rst_stall", b.stall_pc, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(i_addi(5'd1, 5'd0, 12'd5), 32'h100, 0, 0, 5'd0, 32'h0);
    chk("addi_valid", b.id_ex_valid, 1'b1);
    chk("addi_imm", b.id_ex_imm, 32'd5);
    chk("addi_bsel", b.id_ex_bsel, 1'b1);
    chk("addi_regwe", b.id_ex_reg_we, 1'b1);
    cyc(i_add(5'd4, 5'd3, 5'd3), 32'h104, 0, 1, 5'd3, 32'hDEADBEEF);
    chk("wt_rs1d", b.id_ex_rs1d, 32'hDEADBEEF);
    chk("wt_rs2d", b.id_ex_rs2d, 32'hDEADBEEF);
    cyc(i_add(5'd8, 5'd0, 5'd3), 32'h108, 0, 1, 5'd0, 32'h12345678);
    chk("x0_rs1d", b.id_ex_rs1d, 32'h0);
    chk("rf_rs2d", b.id_ex_rs2d, 32'hDEADBEEF);
    cyc(i_addi(5'd2, 5'd0, 12'd1), 32'h10c, 0, 1, 5'd1, 32'h40);
    cyc(i_lw(5'd5, 5'd1, 12'd0), 32'h110, 0, 0, 5'd0, 32'h0);
    drive(i_add(5'd6, 5'd5, 5'd1), 32'h114, 0, 0, 5'd0, 32'h0);
    chk("lu_stall", b.stall_pc, 1'b1);
    chk("lu_pcu", b.pc_update, 32'h114);
    tick();
    chk("lu_bub1", b.id_ex_valid, 1'b0);
    cyc(i_addi(5'd9, 5'd0, 12'd9), 32'h118, 0, 0, 5'd0, 32'h0);
    chk("lu_bub2", b.id_ex_valid, 1'b0);
    cyc(i_add(5'd6, 5'd5, 5'd1), 32'h114, 0, 1, 5'd5, 32'hCAFE0005);
    chk("lu_valid", b.id_ex_valid, 1'b1);
    chk("lu_rs1d", b.id_ex_rs1d, 32'hCAFE0005);
    chk("lu_rs2d", b.id_ex_rs2d, 32'h40);
    cyc(i_lw(5'd5, 5'd1, 12'd4), 32'h120, 0, 0, 5'd0, 32'h0);
    drive(i_sw(5'd5, 5'd2, 12'd4), 32'h124, 0, 0, 5'd0, 32'h0);
    chk("sw_stall", b.stall_pc, 1'b1);
    tick();
    cyc(i_addi(5'd9, 5'd0, 12'd9), 32'h128, 0, 0, 5'd0, 32'h0);
    cyc(i_sw(5'd5, 5'd2, 12'd4), 32'h124, 0, 1, 5'd5, 32'h55);
    chk("sw_memwe", b.id_ex_mem_we, 1'b1);
    cyc(i_lw(5'd0, 5'd1, 12'd0), 32'h130, 0, 0, 5'd0, 32'h0);
    drive(i_add(5'd6, 5'd0, 5'd0), 32'h134, 0, 0, 5'd0, 32'h0);
    chk("x0_nostall", b.stall_pc, 1'b0);
    tick();
    chk("x0_valid", b.id_ex_valid, 1'b1);
    cyc(i_lw(5'd5, 5'd1, 12'd0), 32'h140, 0, 0, 5'd0, 32'h0);
    drive(i_add(5'd6, 5'd5, 5'd5), 32'h144, 1, 0, 5'd0, 32'h0);
    chk("rd_nostall", b.stall_pc, 1'b0);
    tick();
    chk("rd_bub1", b.id_ex_valid, 1'b0);
    cyc(i_addi(5'd9, 5'd0, 12'd9), 32'h148, 0, 0, 5'd0, 32'h0);
    chk("rd_bub2", b.id_ex_valid, 1'b0);
    cyc(i_addi(5'd10, 5'd0, 12'd7), 32'h200, 0, 0, 5'd0, 32'h0);
    chk("rd_target", b.id_ex_pc, 32'h200);
    cyc(i_beq(5'd1, 5'd2, 13'h1FF8), 32'h204, 0, 0, 5'd0, 32'h0);
    chk("beq_imm", b.id_ex_imm, 32'hFFFFFFF8);
    chk("beq_branch", b.id_ex_branch, 1'b1);
    chk("beq_asel", b.id_ex_asel, 1'b1);
    cyc(i_jal(5'd1, 21'd2048), 32'h208, 0, 0, 5'd0, 32'h0);
    chk("jal_imm", b.id_ex_imm, 32'h800);
    chk("jal_jump", b.id_ex_jump, 1'b1);
    chk("jal_wbsel", b.id_ex_wb_sel, 2'd2);
    cyc(i_addi(5'd11, 5'd0, 12'd3), 32'h20c, 0, 0, 5'd0, 32'h0);
    cyc(i_add(5'd12, 5'd3, 5'd3), 32'h210, 1, 0, 5'd0, 32'h0);
    rst = 1'b1;
    #1;
    chk("mrst_idex", act(), z);
    chk("mrst_stall", b.stall_pc, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc(i_add(5'd12, 5'd3, 5'd3), 32'h300, 0, 0, 5'd0, 32'h0);
    chk("mrst_valid", b.id_ex_valid, 1'b1);
    chk("mrst_rf", b.id_ex_rs1d, 32'h0);
    for (int n = 0; n < 400; n++) begin
      in = $urandom;
      k = $urandom_range(0, 11);
      if (k < 9) in[6:0] = ops[k];
      else if (k < 11) in[6:0] = 7'h03;
      in[11:7] = 5'($urandom_range(0, 3));
      in[19:15] = 5'($urandom_range(0, 3));
      in[24:20] = 5'($urandom_range(0, 3));
      cyc(in, $urandom & 32'hFFFFFFFC, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
